salida_puertos: RTL
===================

SALIDA_PUERTOS -- requirements
Module: salida_puertos

Interface
REQ-001 SHALL have parameter PRESCALER_W, default 16, width of the scan prescaler counter.
REQ-002 SHALL have parameter NDIG, default 4, number of display digits; only 4 is supported.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports s0, s1, s2, s3  input  8 each  CPU output ports, i.e. the monociclo s0..s3.
REQ-006 SHALL have port sel  input  1  0 shows {s1,s0}, 1 shows {s3,s2}.
REQ-007 SHALL have port hold  input  1  1 freezes the displayed frame.
REQ-008 SHALL have port an  output  4  digit enables, active-low, an[0] is the least significant digit.
REQ-009 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port nuevo  output  1  one-cycle pulse when any CPU port value changes.

Function
REQ-011 SHALL run prescaler cnt, which increments every cycle and wraps from 2^PRESCALER_W-1 to 0; tick is the cycle where cnt is all-ones.
REQ-012 SHALL hold digit index dig (2 bits), which advances 0->1->2->3->0 only on tick.
REQ-013 SHALL load the 16-bit frame register from the pair chosen by sel when tick=1, dig=3 and hold=0; otherwise frame keeps its value.
REQ-014 SHALL change frame only at this frame boundary, never mid-scan; a sel or hold change affects the display only from the next boundary.
REQ-015 SHALL register an and seg (1-cycle latency): an = all-ones except bit dig cleared; seg = hex decode of frame[4*dig+3:4*dig].
REQ-016 SHALL decode the hex glyphs 0-9, A, b, C, d, E, F; 0 -> 1000000, 8 -> 0000000, A -> 0001000, F -> 0001110.
REQ-017 SHALL register previous copies of s0..s3 every cycle; nuevo = 1 in the cycle after any port differs from its previous copy.
REQ-018 SHALL keep nuevo independent of sel and hold; simultaneous changes on several ports give a single pulse.

Reset
REQ-019 SHALL, while reset=0 at a clock edge, clear cnt, dig, frame, the previous-copy registers and nuevo to 0.
REQ-020 SHALL, during reset, drive an=1111 and seg=1111111 (display dark).
REQ-021 SHALL, on the first cycle after release, drive an=1110 showing frame digit 0 (glyph 0).
REQ-022 SHALL treat reset asserted mid-scan as an abort: the next scan restarts at digit 0 with frame=0.
REQ-023 SHALL compare against the post-reset previous copies of 0, so a nonzero port after release gives one nuevo pulse.

Configuration
REQ-024 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-025 With LEADING_ZERO_BLANK_EN defined, a digit above the most significant nonzero nibble of frame SHALL output seg=1111111, with an still cycling; digit 0 is never blanked.
REQ-026 Without LEADING_ZERO_BLANK_EN, all four digits SHALL always show their glyph, including leading zeros.

Structure
REQ-027 SHALL put the segment glyph constants, the blank constant 1111111 and the NDIG constant in shared package salida_pkg.
REQ-028 SHALL use one sub-module, hex7seg: 4-bit nibble in, 7-bit active-low segments out, purely combinational.

Verification (PRESCALER_W=2, tick every 4 cycles)
REQ-029 Reset for 3 cycles -> an=1111, seg=1111111 throughout; after release an=1110, seg=1000000, nuevo=0 with s*=0.
REQ-030 s0=0x3A, s1=0x12, sel=0, hold=0, one full scan -> next scan shows digits 0..3 as A, 3, 2, 1 (an 1110, 1101, 1011, 0111).
REQ-031 hold=1, then s0 changes to 0xFF -> frame unchanged at the next boundary; nuevo pulses once, 1 cycle after the change.
REQ-032 sel toggles 0->1 mid-scan with s2=0x05, s3=0x00 -> current scan unchanged; the next scan shows 0005.
REQ-033 With LEADING_ZERO_BLANK_EN and frame=0x0005 -> digits 3..1 give seg=1111111 and digit 0 gives seg=0010010; frame=0x0000 shows only 0 on digit 0.
REQ-034 Reset pulsed while dig=2 -> after release the scan restarts at an=1110 with glyph 0.

Source files
------------

// File: rtl/salida_pkg.sv
// -----------------------------------------------------------------------------
// salida_pkg
// Shared constants for the CPU output-port display: supported digit count,
// active-low seven-segment glyphs ({g,f,e,d,c,b,a}, 0 = segment lit) and the
// all-dark pattern.
// No ports (package).
// -----------------------------------------------------------------------------
package salida_pkg;

    // The scan logic and the an/seg ports are built for exactly four digits.
    localparam int NDIG_FIXED = 4;

    // Every segment off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex glyphs, {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;  // lower-case b
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;  // lower-case d
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

endpackage : salida_pkg

// File: rtl/salida_puertos_hex7seg.sv
// -----------------------------------------------------------------------------
// hex7seg
// Purely combinational hex-to-seven-segment decoder.
// Ports:
//   nibble  in   4  value to show (0..F)
//   seg     out  7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module hex7seg
    import salida_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : hex7seg

// File: rtl/salida_puertos.sv
// -----------------------------------------------------------------------------
// salida_puertos
// Shows the single-cycle CPU output ports on a 4-digit multiplexed
// seven-segment display and flags any change on those ports.
//
// A free-running prescaler produces one tick every 2^PRESCALER_W cycles; each
// tick moves the scan to the next digit. The 16-bit frame being displayed is
// captured only when the scan wraps from digit 3 back to digit 0, so a
// selection or hold change never tears a frame mid-scan.
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, digits above the
// most significant nonzero nibble are dark (digit 0 always shows). When not
// defined, every digit shows its glyph, leading zeros included.
//
// Parameters:
//   PRESCALER_W  width of the scan prescaler (tick period 2^PRESCALER_W)
//   NDIG         number of digits, only 4 supported
// Ports:
//   clk     in   1  clock, all state on rising edge
//   reset   in   1  synchronous reset, active-low
//   s0..s3  in   8  CPU output ports
//   sel     in   1  0 -> frame {s1,s0}, 1 -> frame {s3,s2}
//   hold    in   1  1 keeps the current frame at the next boundary
//   an      out  4  digit enables, active-low, an[0] = least significant digit
//   seg     out  7  {g,f,e,d,c,b,a}, active-low
//   nuevo   out  1  one-cycle pulse after any CPU port changes
// -----------------------------------------------------------------------------
module salida_puertos
    import salida_pkg::*;
#(
    parameter int PRESCALER_W = 16,
    parameter int NDIG        = NDIG_FIXED
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s0,
    input  logic [7:0] s1,
    input  logic [7:0] s2,
    input  logic [7:0] s3,
    input  logic       sel,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       nuevo
);

    logic [PRESCALER_W-1:0] cnt;
    logic                   tick;
    logic [1:0]             dig;
    logic [15:0]            frame;
    logic [7:0]             prev0;
    logic [7:0]             prev1;
    logic [7:0]             prev2;
    logic [7:0]             prev3;

    logic [3:0]             nibble;
    logic [6:0]             glyph;
    logic                   blank;
    logic [NDIG-1:0]        an_next;
    logic                   changed;
    logic                   frame_load;

    assign tick       = &cnt;
    assign frame_load = tick && (dig == 2'd3) && !hold;

    assign nibble = frame[{dig, 2'b00} +: 4];

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (glyph)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every nibble above it are zero.
    always_comb begin
        blank = 1'b0;
        case (dig)
            2'd0: blank = 1'b0;
            2'd1: blank = (frame[15:4]  == 12'h000);
            2'd2: blank = (frame[15:8]  == 8'h00);
            2'd3: blank = (frame[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // One-cold digit enable for the digit currently being scanned.
    always_comb begin
        an_next = '1;
        for (int i = 0; i < NDIG; i++) begin
            an_next[i] = (dig != i[1:0]);
        end
    end

    // Several ports changing in the same cycle still collapse to one pulse.
    assign changed = (s0 != prev0) || (s1 != prev1) ||
                     (s2 != prev2) || (s3 != prev3);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt   <= '0;
            dig   <= '0;
            frame <= '0;
            prev0 <= '0;
            prev1 <= '0;
            prev2 <= '0;
            prev3 <= '0;
            nuevo <= 1'b0;
            an    <= '1;
            seg   <= SEG_BLANK;
        end else begin
            cnt <= cnt + 1'b1;
            if (tick) begin
                dig <= dig + 1'b1;
            end
            if (frame_load) begin
                frame <= sel ? {s3, s2} : {s1, s0};
            end
            an    <= an_next;
            seg   <= blank ? SEG_BLANK : glyph;
            prev0 <= s0;
            prev1 <= s1;
            prev2 <= s2;
            prev3 <= s3;
            nuevo <= changed;
        end
    end

endmodule : salida_puertos
